// File: rtl/fft_coeff_loader.sv
// rtl/fft_coeff_loader.sv - AHB-Lite initiator streaming window coefficients into the FFT coefficient RAM
// Optional running checksum of written coefficients: define COEFF_LOADER_CKSUM_EN.
module fft_coeff_loader #(
   parameter int          DW        = 16,
   parameter int          DATA_CNT  = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          len_err,
   output logic [31:0]   cksum,
   input  logic [DW-1:0] tdata_s,
   input  logic          tvalid_s,
   input  logic          tlast_s,
   output logic          tready_s,
   output logic [31:0]   haddr_m,
   output logic [2:0]    hburst_m,
   output logic [2:0]    hsize_m,
   output logic [1:0]    htrans_m,
   output logic [31:0]   hwdata_m,
   output logic          hwrite_m,
   input  logic [31:0]   hrdata_m,
   input  logic          hready_m,
   input  logic          hresp_m
);
   localparam int            IW        = $clog2(DATA_CNT) + 1;
   localparam logic [IW-1:0] CNT       = IW'(DATA_CNT);
   localparam logic [1:0]    HT_IDLE   = 2'b00;
   localparam logic [1:0]    HT_NONSEQ = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_ABORT, S_FINISH} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] idx;
   logic [15:0]   ap_half;
   logic          dp_valid;
   logic          start_ok, accept, last_beat, ahb_err1, dp_ok;
   logic          unused_hrdata;

   assign unused_hrdata = ^hrdata_m;

   assign hburst_m  = 3'b000;
   assign hsize_m   = 3'b001;
   assign hwrite_m  = 1'b1;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FINISH);
   assign start_ok  = (state == S_IDLE) && start;
   assign accept    = tvalid_s && tready_s;
   assign last_beat = tlast_s || (idx == CNT - IW'(1));
   // First ERROR cycle; only meaningful while a data phase is outstanding.
   assign ahb_err1  = dp_valid && hresp_m && !hready_m;
   assign dp_ok     = dp_valid && hready_m && !hresp_m;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      tready_s = 1'b0;
      case (state)
         S_IDLE:   if (start) state_nx = S_RUN;
         S_RUN: begin
            tready_s = hready_m && !hresp_m && (idx < CNT);
            if (ahb_err1)                state_nx = S_ABORT;
            else if (accept && last_beat) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (ahb_err1)                               state_nx = S_ABORT;
            else if (hready_m && htrans_m == HT_IDLE)   state_nx = S_FINISH;
         end
         S_ABORT:  if (hready_m) state_nx = S_FINISH;
         S_FINISH: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Address phase (htrans/haddr/ap_half) and data phase (dp_valid/hwdata) advance only on hready.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx      <= '0;
         ap_half  <= '0;
         dp_valid <= 1'b0;
         htrans_m <= HT_IDLE;
         haddr_m  <= '0;
         hwdata_m <= '0;
         err      <= 1'b0;
         len_err  <= 1'b0;
      end else begin
         if (start_ok) begin
            idx     <= '0;
            err     <= 1'b0;
            len_err <= 1'b0;
         end
         if (ahb_err1) begin
            htrans_m <= HT_IDLE;
            err      <= 1'b1;
         end else if (hready_m) begin
            dp_valid <= (htrans_m == HT_NONSEQ);
            if (htrans_m == HT_NONSEQ) hwdata_m <= {ap_half, ap_half};
            if (accept) begin
               htrans_m <= HT_NONSEQ;
               haddr_m  <= BASE_ADDR + 32'({idx, 1'b0});
               ap_half  <= 16'(tdata_s);
               idx      <= idx + IW'(1);
               if (last_beat) len_err <= !(tlast_s && idx == CNT - IW'(1));
            end else begin
               htrans_m <= HT_IDLE;
            end
         end
      end
   end

`ifdef COEFF_LOADER_CKSUM_EN
   logic [31:0] cksum_q;

   always_ff @(posedge clk) begin
      if (reset)         cksum_q <= '0;
      else if (start_ok) cksum_q <= '0;
      else if (dp_ok)    cksum_q <= cksum_q + {16'h0, hwdata_m[15:0]};
   end

   assign cksum = cksum_q;
`else
   logic unused_dp_ok;

   assign unused_dp_ok = dp_ok;
   assign cksum        = 32'h0;
`endif

endmodule

// File: tb/tb_fft_coeff_loader.sv
// tb/tb_fft_coeff_loader.sv - randomized bench for fft_coeff_loader against a stream/AHB transaction model
module tb_fft_coeff_loader;
   localparam int          DW   = 16;
   localparam int          CNT  = 8;
   localparam logic [31:0] BASE = 32'h100;
`ifdef COEFF_LOADER_CKSUM_EN
   localparam bit CK_ON = 1'b1;
`else
   localparam bit CK_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, busy, done, err, len_err;
   logic [31:0]   cksum;
   logic [DW-1:0] tdata_s;
   logic          tvalid_s, tlast_s, tready_s;
   logic [31:0]   haddr_m, hwdata_m, hrdata_m;
   logic [2:0]    hburst_m, hsize_m;
   logic [1:0]    htrans_m;
   logic          hwrite_m, hready_m, hresp_m;

   int total = 0;
   int bad   = 0;

   logic [15:0] src_d[$];
   bit          src_l[$];

   always #5 clk = ~clk;

   fft_coeff_loader #(.DW(DW), .DATA_CNT(CNT), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
      .len_err(len_err), .cksum(cksum), .tdata_s(tdata_s), .tvalid_s(tvalid_s),
      .tlast_s(tlast_s), .tready_s(tready_s), .haddr_m(haddr_m), .hburst_m(hburst_m),
      .hsize_m(hsize_m), .htrans_m(htrans_m), .hwdata_m(hwdata_m), .hwrite_m(hwrite_m),
      .hrdata_m(hrdata_m), .hready_m(hready_m), .hresp_m(hresp_m)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One load: n beats, tlast at last_pos (-1 none), gap_mode 0=always 1=1,0,0 2=random,
   // wait_beat gets 2 wait states, err_beat gets ERROR, reset_at resets after that many accepts.
   task automatic run_load(input int n, input int last_pos, input bit seq, input int gap_mode,
                           input bit rand_wait, input int wait_beat, input int err_beat,
                           input int reset_at, input bit hold_start, input int exp_done_cyc);
      int          exp_acc, n_ok, ok_n, acc_n, sp, cyc, exp_ap, exp_dp, waits_left, err_ph, rst_ph;
      bit          exp_len, running, fin, pend, hr, hp;
      logic [31:0] exp_sum, ok_sum;
      logic [15:0] acc_d[$];

      src_d.delete();
      src_l.delete();
      for (int i = 0; i < n; i++) begin
         src_d.push_back(seq ? 16'(i + 1) : 16'($urandom));
         src_l.push_back(i == last_pos);
      end
      exp_acc = CNT;
      exp_len = 1'b1;
      if (last_pos >= 0 && last_pos < CNT) begin
         exp_acc = last_pos + 1;
         exp_len = (last_pos != CNT - 1);
      end
      n_ok = (err_beat >= 0) ? err_beat : exp_acc;
      exp_sum = 0;
      for (int i = 0; i < n_ok; i++) exp_sum += 32'(src_d[i]);

      @(posedge clk); #1;
      start = 1'b1; tvalid_s = 1'b0; hready_m = 1'b1; hresp_m = 1'b0;
      cyc = 0; sp = 0; acc_n = 0; ok_n = 0; ok_sum = 0; exp_ap = -1; exp_dp = -1;
      waits_left = 2; err_ph = 0; rst_ph = 0; running = 1'b1; fin = 1'b0; pend = 1'b0;
      acc_d.delete();

      while (!fin) begin
         @(posedge clk); #1;
         cyc++;
         hr = 1'b1;
         hp = 1'b0;
         if (rst_ph == 1) begin
            rst_ph = 2; reset = 1'b0; start = 1'b0; tvalid_s = 1'b0;
         end else begin
            start = hold_start;
            if (!pend && sp < n) begin
               case (gap_mode)
                  0:       pend = 1'b1;
                  1:       pend = (cyc % 3 == 1);
                  default: pend = ($urandom_range(0, 1) == 1);
               endcase
            end
            tvalid_s = pend;
            if (pend) begin
               tdata_s = src_d[sp];
               tlast_s = src_l[sp];
            end
            if (err_ph == 1) begin
               hp = 1'b1; err_ph = 2;
            end else if (err_ph == 0 && err_beat >= 0 && exp_dp == err_beat) begin
               hr = 1'b0; hp = 1'b1; err_ph = 1;
            end else if (exp_dp >= 0 && exp_dp == wait_beat && waits_left > 0) begin
               hr = 1'b0; waits_left--;
            end else if (exp_dp >= 0 && rand_wait && $urandom_range(0, 3) == 0) begin
               hr = 1'b0;
            end
            if (reset_at >= 0 && acc_n >= reset_at) begin
               reset = 1'b1; rst_ph = 1;
            end
         end
         hready_m = hr;
         hresp_m  = hp;

         @(negedge clk);
         if (rst_ph == 2) begin
            chk("rst_htrans", 32'(htrans_m), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_tready", 32'(tready_s), 32'(0));
            fin = 1'b1;
         end else if (rst_ph == 0) begin
            if (cyc == 1) begin
               chk("start_err_clr", 32'(err), 32'(0));
               chk("start_len_clr", 32'(len_err), 32'(0));
               chk("start_ck_clr", cksum, 32'(0));
            end
            chk("tready", 32'(tready_s), 32'(running && hr && !hp && acc_n < CNT));
            chk("htrans", 32'(htrans_m), (exp_ap >= 0) ? 32'h2 : 32'h0);
            if (exp_ap >= 0) chk("haddr", haddr_m, BASE + 32'(2 * exp_ap));
            if (exp_dp >= 0) chk("hwdata", hwdata_m, {acc_d[exp_dp], acc_d[exp_dp]});
            if (done) begin
               fin = 1'b1;
               chk("done_err", 32'(err), 32'(err_beat >= 0));
               if (err_beat < 0) begin
                  chk("done_len_err", 32'(len_err), 32'(exp_len));
                  chk("done_accepted", 32'(acc_n), 32'(exp_acc));
               end
               chk("done_writes", 32'(ok_n), 32'(n_ok));
               chk("done_wsum", ok_sum, exp_sum);
               chk("done_cksum", cksum, CK_ON ? exp_sum : 32'h0);
               chk("done_pipe_empty", 32'(exp_ap >= 0 || exp_dp >= 0), 32'(0));
               if (exp_done_cyc > 0) chk("done_latency", 32'(cyc), 32'(exp_done_cyc));
            end else begin
               chk("busy", 32'(busy), 32'(1));
            end
            if (hp && !hr) begin
               running = 1'b0;
               exp_ap  = -1;
            end else if (hr) begin
               if (exp_dp >= 0 && !hp) begin
                  ok_n++;
                  ok_sum += 32'(acc_d[exp_dp]);
               end
               exp_dp = exp_ap;
               exp_ap = -1;
               if (tvalid_s && tready_s) begin
                  exp_ap = acc_n;
                  acc_d.push_back(tdata_s);
                  acc_n++;
                  sp++;
                  pend = 1'b0;
                  if (tlast_s || acc_n == CNT) running = 1'b0;
               end
            end
            if (cyc > 200) begin
               chk("timeout_no_done", 32'(1), 32'(0));
               fin = 1'b1;
            end
         end
      end

      @(posedge clk); #1;
      start = 1'b0; tvalid_s = 1'b0; hready_m = 1'b1; hresp_m = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk("post_busy", 32'(busy), 32'(0));
      chk("post_done", 32'(done), 32'(0));
      chk("post_htrans", 32'(htrans_m), 32'(0));
   endtask

   initial begin
      int lp, n, eb, ea;
      reset = 1'b1; start = 1'b0; tvalid_s = 1'b0; tdata_s = '0; tlast_s = 1'b0;
      hready_m = 1'b1; hresp_m = 1'b0; hrdata_m = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy0", 32'(busy), 32'(0));
      chk("rst_done0", 32'(done), 32'(0));
      chk("rst_err0", 32'(err), 32'(0));
      chk("rst_len0", 32'(len_err), 32'(0));
      chk("rst_cksum0", cksum, 32'(0));
      chk("rst_tready0", 32'(tready_s), 32'(0));
      chk("rst_htrans0", 32'(htrans_m), 32'(0));
      chk("rst_haddr0", haddr_m, 32'(0));
      chk("rst_hwdata0", hwdata_m, 32'(0));
      chk("hburst", 32'(hburst_m), 32'(0));
      chk("hsize", 32'(hsize_m), 32'(1));
      chk("hwrite", 32'(hwrite_m), 32'(1));
      @(posedge clk); #1;
      reset = 1'b0;

      run_load(8, 7, 1, 0, 0, -1, -1, -1, 1, 11);  // zero-wait burst, start held through done
      run_load(8, 7, 1, 0, 0,  2, -1, -1, 0, 13);  // two wait states on the third write
      run_load(8, 7, 1, 1, 0, -1, -1, -1, 0, -1);  // tvalid gaps
      run_load(8, 4, 1, 0, 0, -1, -1, -1, 0, -1);  // early tlast
      run_load(9, -1, 1, 0, 0, -1, -1, -1, 0, -1); // no tlast, extra beat
      run_load(8, 7, 1, 0, 0, -1,  2, -1, 0, -1);  // ERROR on 0x104
      run_load(8, 7, 0, 0, 0, -1, -1, -1, 0, 11);  // clears err
      run_load(8, 7, 1, 0, 0, -1, -1,  4, 0, -1);  // reset mid-load
      run_load(8, 7, 1, 2, 1, -1, -1, -1, 0, -1);  // reload from base

      for (int k = 0; k < 14; k++) begin
         lp = $urandom_range(0, CNT);
         n  = (lp == CNT) ? CNT + $urandom_range(0, 2) : lp + 1 + $urandom_range(0, 2);
         ea = (lp == CNT) ? CNT : lp + 1;
         eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ea - 1) : -1;
         run_load(n, (lp == CNT) ? -1 : lp, 0, 2, 1, -1, eb, -1, k[0], -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fft_coeff_loader.md
Name: fft_coeff_loader

Overview:
- AHB-Lite initiator that streams window coefficients from an AXI-Stream source into the FFT window's AHB coefficient RAM.
- Coefficient index i is written to BASE_ADDR + 2*i as a halfword write.
- Sits between the control CPU's coefficient DMA stream and the window's AHB slave port, so the CPU does not run per-word AHB writes.
- Pipelined: the address phase of beat i+1 overlaps the data phase of beat i.

Parameters:
- DW, 16, coefficient width (≤16; zero-extended to the halfword).
- DATA_CNT, 1024, coefficients per load (power of two, ≤1024).
- BASE_ADDR, 32'h0000_0000, AHB byte address of coefficient 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- busy  out  1  high from the cycle after start until completion.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky: AHB ERROR seen; cleared by next accepted start.
- len_err  out  1  sticky: tlast position ≠ DATA_CNT; cleared by next accepted start.
- cksum  out  32  running sum of written coefficients (optional feature).
- tdata_s  in  DW  coefficient data.
- tvalid_s  in  1  coefficient valid.
- tlast_s  in  1  last coefficient.
- tready_s  out  1  coefficient accepted when tvalid_s && tready_s.
- haddr_m  out  32  AHB address.
- hburst_m  out  3  fixed 3'b000 (SINGLE).
- hsize_m  out  3  fixed 3'b001 (halfword).
- htrans_m  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- hwdata_m  out  32  {coeff, coeff}; the halfword is replicated on both lanes.
- hwrite_m  out  1  fixed 1.
- hrdata_m  in  32  unused.
- hready_m  in  1  AHB HREADY.
- hresp_m  in  1  AHB HRESP (1 = ERROR).

Behaviour:
- Reset (synchronous, reset=1 at posedge): all outputs 0 except the fixed hburst_m/hsize_m/hwrite_m values; state IDLE, idx=0, cksum=0.
  - Reset mid-transfer drops any outstanding transfer; htrans_m=IDLE the next cycle.
- States:
  - IDLE: start → RUN; err, len_err, idx and cksum are cleared. start while busy is ignored.
  - RUN: tready_s = hready_m && !hresp_m && idx<DATA_CNT && !stop. Combinational from hready_m; no combinational path from tvalid_s.
  - DRAIN: the last address phase has been issued; wait for its data phase to finish (hready_m=1).
  - ABORT: entered on ERROR; drives IDLE, waits for the second ERROR cycle.
  - Every terminal path goes through one FINISH cycle: done=1, then IDLE.
- Address phase:
  - On an accepted beat: htrans_m=NONSEQ, haddr_m=BASE_ADDR+{idx,1'b0}; coefficient latched; idx+1.
  - No beat accepted while hready_m=1 → htrans_m=IDLE.
  - While hready_m=0, haddr_m, htrans_m and hwdata_m are held stable.
- Data phase: in the cycle after the address phase is sampled (hready_m=1), hwdata_m = latched coefficient; held until hready_m=1.
- Throughput and latency:
  - Back-to-back: one write per clock with continuous tvalid_s and zero-wait slave.
  - tvalid_s→NONSEQ on haddr_m: 1 cycle. Accepted beat→hwdata_m: 2 cycles.
- Termination:
  - tlast_s accepted → stop; DRAIN. len_err=1 if idx+1≠DATA_CNT.
  - idx reaches DATA_CNT without tlast → stop; DRAIN; len_err=1. Extra beats are not accepted.
  - tlast on beat DATA_CNT-1: normal completion, len_err=0.
- ERROR response:
  - First cycle (hresp_m=1, hready_m=0): htrans_m forced IDLE next cycle; pending address phase cancelled; tready_s=0; err=1.
  - Second cycle (hready_m=1) → FINISH. Remaining stream beats are left unconsumed.
- Simultaneous start and done: the start is ignored (busy still 1 that cycle).

Optional Feature:
- Macro COEFF_LOADER_CKSUM_EN.
- Defined: cksum accumulates the zero-extended coefficient at each completed (OKAY) data phase, mod 2^32. It is valid when done pulses and cleared on accepted start.
- Undefined: cksum tied to 32'h0 and no adder is synthesised.

Test Plan:
- DATA_CNT=8, BASE=0x100, stream 0x0001..0x0008, tlast on 8th, hready=1.
  - Required: NONSEQ at 0x100,0x102,…,0x10E on consecutive cycles; hwdata 0x00010001…0x00080008 one cycle later.
  - done after final data phase; len_err=0; err=0; cksum=36 (macro on).
- Same stream, slave inserts 2 wait states on the 3rd transfer.
  - Required: haddr_m=0x106 and hwdata_m=0x00030003 held stable during the waits; tready_s=0 during the waits; all 8 writes correct.
- tvalid_s gaps (pattern 1,0,0,1…): htrans_m=IDLE in gap cycles; addresses still contiguous.
- tlast on 5th beat (DATA_CNT=8): 5 writes, done, len_err=1.
  - 9 beats with no tlast: only 8 accepted, len_err=1.
- ERROR on write to 0x104: err=1; htrans_m=IDLE in the cycle after the first ERROR cycle; no write to 0x106 completes; done pulses; next start clears err.
- reset asserted mid-load (idx=4): next cycle htrans_m=IDLE, busy=0. A new start reloads from 0x100.
